// File: rtl/display_scan_driver.sv
// rtl/display_scan_driver.sv - 8-bit value to 3-digit BCD with multiplexed common-anode seven-segment scan
// Optional feature macro: DISP_LZ_BLANK_EN (leading-zero blanking of hundreds/tens digits)
module display_scan_driver #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] display,
  output logic [6:0] seg,
  output logic       dp,
  output logic [2:0] an,
  output logic       busy,
  output logic       bcd_valid
);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  localparam logic [19:0] REF_LAST = 20'(REFRESH_DIV - 1);

  state_t      state, state_nxt;
  logic [7:0]  last_val, last_val_nxt;
  logic [19:0] shreg, shreg_nxt;
  logic [19:0] adj;
  logic [2:0]  bitcnt, bitcnt_nxt;
  logic [3:0]  dig0, dig1, dig2;
  logic [3:0]  dig0_nxt, dig1_nxt, dig2_nxt;
  logic        busy_nxt, bcd_valid_nxt;
  logic [19:0] refcnt;
  logic [1:0]  scan_idx;
  logic [6:0]  seg_nxt;
  logic [2:0]  an_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  assign dp = 1'b1;

  // Add-3 correction on each BCD nibble before the shift (binary occupies bits [7:0])
  always_comb begin
    adj = shreg;
    if (shreg[11:8]  >= 4'd5) adj[11:8]  = shreg[11:8]  + 4'd3;
    if (shreg[15:12] >= 4'd5) adj[15:12] = shreg[15:12] + 4'd3;
    if (shreg[19:16] >= 4'd5) adj[19:16] = shreg[19:16] + 4'd3;
  end

  // Conversion FSM next-state and datapath: capture on change, 8 shift cycles, then load digits
  always_comb begin
    state_nxt     = state;
    last_val_nxt  = last_val;
    shreg_nxt     = shreg;
    bitcnt_nxt    = bitcnt;
    dig0_nxt      = dig0;
    dig1_nxt      = dig1;
    dig2_nxt      = dig2;
    busy_nxt      = busy;
    bcd_valid_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (display != last_val) begin
          last_val_nxt = display;
          shreg_nxt    = {12'b0, display};
          bitcnt_nxt   = 3'd0;
          busy_nxt     = 1'b1;
          state_nxt    = CONV;
        end
      end
      CONV: begin
        shreg_nxt  = adj << 1;
        bitcnt_nxt = bitcnt + 3'd1;
        if (bitcnt == 3'd7) state_nxt = LOAD;
      end
      LOAD: begin
        dig0_nxt      = shreg[11:8];
        dig1_nxt      = shreg[15:12];
        dig2_nxt      = shreg[19:16];
        bcd_valid_nxt = 1'b1;
        busy_nxt      = 1'b0;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Conversion state and digit registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last_val  <= 8'd0;
      shreg     <= 20'd0;
      bitcnt    <= 3'd0;
      dig0      <= 4'd0;
      dig1      <= 4'd0;
      dig2      <= 4'd0;
      busy      <= 1'b0;
      bcd_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_val  <= last_val_nxt;
      shreg     <= shreg_nxt;
      bitcnt    <= bitcnt_nxt;
      dig0      <= dig0_nxt;
      dig1      <= dig1_nxt;
      dig2      <= dig2_nxt;
      busy      <= busy_nxt;
      bcd_valid <= bcd_valid_nxt;
    end
  end

  // Dwell counter; each wrap moves the scan to the next digit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      refcnt   <= 20'd0;
      scan_idx <= 2'd0;
    end else if (refcnt == REF_LAST) begin
      refcnt   <= 20'd0;
      scan_idx <= (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
    end else begin
      refcnt <= refcnt + 20'd1;
    end
  end

  // Segment pattern and anode select for the digit currently being scanned
  always_comb begin
    seg_nxt = 7'h7F;
    an_nxt  = 3'b111;
    case (scan_idx)
      2'd0: begin
        an_nxt  = 3'b110;
        seg_nxt = seg_decode(dig0);
      end
      2'd1: begin
        an_nxt  = 3'b101;
        seg_nxt = seg_decode(dig1);
`ifdef DISP_LZ_BLANK_EN
        if (dig2 == 4'd0 && dig1 == 4'd0) seg_nxt = 7'h7F;
`endif
      end
      2'd2: begin
        an_nxt  = 3'b011;
        seg_nxt = seg_decode(dig2);
`ifdef DISP_LZ_BLANK_EN
        if (dig2 == 4'd0) seg_nxt = 7'h7F;
`endif
      end
      default: begin
        an_nxt  = 3'b111;
        seg_nxt = 7'h7F;
      end
    endcase
  end

  // an and seg registered together so they always switch on the same edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg <= 7'h7F;
      an  <= 3'b111;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule
